// File: rtl/p19_tinyqv_mem_responder_pkg.sv
// Shared definitions for the TinyQV nibble-serial memory responder:
// access-size encodings carried in mem_op[1:0] and the responder state machine.
package p19_tinyqv_mem_responder_pkg;

  localparam logic [1:0] MEM_OP_BYTE = 2'b00;
  localparam logic [1:0] MEM_OP_HALF = 2'b01;
  localparam logic [1:0] MEM_OP_WORD = 2'b10;

  localparam logic [2:0] COUNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
  } state_t;

endpackage

// File: rtl/p19_tinyqv_mem_array.sv
// Word-organised backing store with per-byte write enables and an
// asynchronous read port; contents are never cleared.
module p19_tinyqv_mem_array
  import p19_tinyqv_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic [3:0]           byte_we,
  input  logic [ADDR_BITS-3:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-3:0] raddr,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/p19_tinyqv_mem_responder.sv
// Memory responder for the TinyQV nibble-serial bus: captures store data,
// commits stores at the address strobe and replays load words after LATENCY frames.
module p19_tinyqv_mem_responder
  import p19_tinyqv_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  counter,
  input  logic        address_ready,
  input  logic [27:0] addr_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        load_data_ready,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] WAIT_LAST = 2'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic [27:0] capture_p0;
  logic [31:0] store_word;
  logic [31:0] ld_word_p1;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [3:0]  byte_we;
  logic [1:0]  size;
  logic [1:0]  offset;
  logic        frame_end;
  logic        accept;
  logic        in_range;
  logic        misaligned;
  logic        load_go;
  logic        store_go;
  logic        unused_bits;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      MEM_OP_BYTE: return 1'b0;
      MEM_OP_HALF: return off[0];
      default:     return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      MEM_OP_BYTE: return 4'b0001 << off;
      MEM_OP_HALF: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [1:0] off,
                                            input logic [31:0] word);
    case (sz)
      MEM_OP_BYTE: return {24'd0, word[7:0]} << {off, 3'b000};
      MEM_OP_HALF: return {16'd0, word[15:0]} << {off, 3'b000};
      default:     return word;
    endcase
  endfunction

  // The signedness bit only matters to the core's own extension logic.
  assign unused_bits = mem_op[2];

  assign size       = mem_op[1:0];
  assign offset     = addr_in[1:0];
  assign frame_end  = counter == COUNT_LAST;
  assign accept     = address_ready && frame_end && !rst;
  assign in_range   = (addr_in >> ADDR_BITS) == 28'd0;
  assign misaligned = is_misaligned(size, offset);
  assign store_word = {data_in, capture_p0};

  // Stores commit even mid-load; loads are only taken when idle.
  assign load_go  = accept && is_load && (state == ST_IDLE);
  assign store_go = accept && is_store && in_range && !misaligned;
  assign err      = accept && in_range && misaligned && (is_store || load_go);
  assign byte_we  = store_go ? lane_mask(size, offset) : 4'b0000;
  assign wdata    = lane_data(size, offset, store_word);

  p19_tinyqv_mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk    (clk),
    .byte_we(byte_we),
    .waddr  (addr_in[ADDR_BITS-1:2]),
    .wdata  (wdata),
    .raddr  (addr_in[ADDR_BITS-1:2]),
    .rdata  (rdata)
  );

  // Stage p0: nibble shift register, oldest nibble ends up in the low bits
  always_ff @(posedge clk) begin
    capture_p0 <= store_word[31:4];
  end

  // Stage p1: load word aligned to the requested byte at acceptance
  always_ff @(posedge clk) begin
    if (load_go) begin
      ld_word_p1 <= (in_range && !misaligned) ? (rdata >> {offset, 3'b000}) : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    load_data_ready = 1'b0;
    busy            = 1'b0;
    data_out        = 4'd0;
    case (state)
      ST_IDLE: begin
        if (load_go) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = 2'd0;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (frame_end) begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt    = ST_DATA;
            wait_cnt_nxt = 2'd0;
          end else begin
            wait_cnt_nxt = wait_cnt + 2'd1;
          end
        end
      end
      ST_DATA: begin
        busy            = 1'b1;
        load_data_ready = 1'b1;
        data_out        = ld_word_p1[{counter, 2'b00} +: 4];
        if (frame_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_p19_tinyqv_mem_responder.sv
// Scoreboard bench for the TinyQV memory responder: a frame-level model predicts
// load words, data-frame timing, busy and err; a monitor compares each clock.
module tb_p19_tinyqv_mem_responder;

  localparam int AB = 6;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst3, address_ready, address_ready3, is_load, is_store;
  logic [2:0]  counter, mem_op;
  logic [27:0] addr_in;
  logic [3:0]  data_in, data_out, data_out3;
  logic        ldr, busy, err, ldr3, busy3, err3;

  p19_tinyqv_mem_responder #(.ADDR_BITS(AB), .LATENCY(L1)) dut (
    .clk(clk), .rst(rst), .counter(counter), .address_ready(address_ready),
    .addr_in(addr_in), .is_load(is_load), .is_store(is_store), .mem_op(mem_op),
    .data_in(data_in), .data_out(data_out), .load_data_ready(ldr),
    .busy(busy), .err(err)
  );

  p19_tinyqv_mem_responder #(.ADDR_BITS(AB), .LATENCY(L3)) dut3 (
    .clk(clk), .rst(rst3), .counter(counter), .address_ready(address_ready3),
    .addr_in(addr_in), .is_load(is_load), .is_store(is_store), .mem_op(mem_op),
    .data_in(data_in), .data_out(data_out3), .load_data_ready(ldr3),
    .busy(busy3), .err(err3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (frame %0d count %0d)", name, act, exp,
               frame_no, counter);
    end
  endtask

  // Reference model: byte memory, last accepted load frame, expected load queue
  typedef struct {
    logic [31:0] word;
    int          frame;
  } exp_t;

  logic [7:0] mem_m [64];
  exp_t       sb [$];
  int         frame_no   = 0;
  int         acc_frame  = -100;
  logic       exp_err    = 1'b0;
  logic       rst3_q     = 1'b0;
  bit         ldr3_seen  = 1'b0;

  function automatic bit model_busy();
    return (frame_no > acc_frame) && (frame_no <= acc_frame + 1 + L1);
  endfunction

  function automatic int size_of(input logic [1:0] op);
    return (op == 2'b00) ? 1 : (op == 2'b01) ? 2 : 4;
  endfunction

  task automatic do_frame(input bit rdy, input bit to3, input bit ld, input bit st,
                          input logic [27:0] a, input logic [2:0] op,
                          input logic [31:0] d, input int spur, input int rst3_at);
    int ai, n, base;
    bit ok, take_ld;
    logic [31:0] w;
    ai      = int'(a);
    n       = size_of(op[1:0]);
    ok      = (ai < 64) && (ai % n == 0);
    take_ld = !to3 && rdy && ld && !model_busy();
    for (int k = 0; k < 8; k++) begin
      counter        = 3'(k);
      data_in        = d[4*k +: 4];
      is_load        = ld;
      is_store       = st;
      addr_in        = a;
      mem_op         = op;
      address_ready  = !to3 && ((rdy && k == 7) || k == spur);
      address_ready3 = to3 && rdy && k == 7;
      rst3           = (k == rst3_at);
      exp_err        = (k == 7) && !to3 && rdy && (ai < 64) && (ai % n != 0) && (st || take_ld);
      @(posedge clk);
      if (k == 7 && !to3 && rdy) begin
        if (st && ok) begin
          for (int i = 0; i < n; i++) mem_m[ai + i] = d[8*i +: 8];
        end
        if (take_ld) begin
          base = ai - (ai % 4);
          w = ok ? ({mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]} >> (8 * (ai % 4)))
                 : 32'd0;
          sb.push_back('{w, frame_no + 1 + L1});
          acc_frame = frame_no;
        end
      end
      #1;
    end
    frame_no++;
  endtask

  task automatic idle(input int nf);
    for (int i = 0; i < nf; i++) do_frame(0, 0, 0, 0, 28'd0, 3'd2, $urandom, -1, -1);
  endtask

  // Monitor for the LATENCY=1 instance
  exp_t        cur;
  bit          collecting = 1'b0;
  logic [31:0] got;

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, model_busy());
      chk("err", err, exp_err);
      if (ldr) begin
        if (counter == 3'd0) begin
          if (sb.size() == 0) begin
            chk("unexpected_frame", ldr, 0);
          end else begin
            cur = sb.pop_front();
            collecting = 1'b1;
            chk("frame_timing", frame_no, cur.frame);
          end
        end else if (!collecting) begin
          chk("stray_ready", ldr, 0);
        end
        if (collecting) begin
          got[4*counter +: 4] = data_out;
          if (counter == 3'd7) begin
            chk("load_word", got, cur.word);
            collecting = 1'b0;
          end
        end
      end else begin
        chk("data_out_idle", data_out, 0);
        if (collecting) begin
          chk("ready_dropped", ldr, 1);
          collecting = 1'b0;
        end
      end
    end
  end

  // Monitor for the LATENCY=3 instance used for the reset-abort case
  always @(posedge clk) rst3_q <= rst3;
  always @(negedge clk) begin
    if (ldr3 === 1'b1 || (data_out3 !== 4'd0 && data_out3 !== 4'bx)) ldr3_seen = 1'b1;
    if (rst3_q) begin
      chk("busy3_after_rst", busy3, 0);
      chk("err3_after_rst", err3, 0);
    end
  end

  initial begin
    int ld, r;
    logic [27:0] a;
    rst = 1'b1; rst3 = 1'b1;
    address_ready = 1'b0; address_ready3 = 1'b0;
    is_load = 1'b0; is_store = 1'b0; counter = 3'd0; mem_op = 3'd0;
    addr_in = 28'd0; data_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ldr", ldr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_busy3", busy3, 0);
    rst = 1'b0; rst3 = 1'b0;

    for (int w = 0; w < 16; w++) do_frame(1, 0, 0, 1, 28'(w * 4), 3'd2, $urandom, -1, -1);

    // Word store then immediate word load
    do_frame(1, 0, 0, 1, 28'h10, 3'd2, 32'hDEADBEEF, -1, -1);
    do_frame(1, 0, 1, 0, 28'h10, 3'd2, $urandom, -1, -1);
    idle(2);
    // Byte store into lane 2, word and byte reload
    do_frame(1, 0, 0, 1, 28'h12, 3'd0, 32'h1234565A, -1, -1);
    do_frame(1, 0, 1, 0, 28'h10, 3'd2, $urandom, -1, -1);
    idle(2);
    do_frame(1, 0, 1, 0, 28'h13, 3'd4, $urandom, -1, -1);
    idle(2);
    // Misaligned half load and half store
    do_frame(1, 0, 1, 0, 28'h11, 3'd1, $urandom, -1, -1);
    idle(2);
    do_frame(1, 0, 0, 1, 28'h11, 3'd1, 32'hFFFFFFFF, -1, -1);
    do_frame(1, 0, 1, 0, 28'h10, 3'd2, $urandom, -1, -1);
    idle(2);
    // Out of range store and load
    do_frame(1, 0, 0, 1, 28'h100, 3'd2, 32'h0BADF00D, -1, -1);
    do_frame(1, 0, 1, 0, 28'h100, 3'd2, $urandom, -1, -1);
    idle(2);
    // Loads presented while busy are dropped
    do_frame(1, 0, 1, 0, 28'h10, 3'd2, $urandom, -1, -1);
    do_frame(1, 0, 1, 0, 28'h14, 3'd2, $urandom, -1, -1);
    do_frame(1, 0, 1, 0, 28'h18, 3'd2, $urandom, -1, -1);
    do_frame(1, 0, 1, 0, 28'h1C, 3'd2, $urandom, -1, -1);
    idle(2);
    // Strobes away from count 7 are ignored
    do_frame(0, 0, 1, 0, 28'h20, 3'd2, $urandom, 3, -1);
    do_frame(0, 0, 0, 1, 28'h20, 3'd2, $urandom, 5, -1);
    do_frame(1, 0, 1, 0, 28'h20, 3'd2, $urandom, -1, -1);
    idle(2);

    for (int i = 0; i < 160; i++) begin
      r  = $urandom_range(0, 9);
      ld = $urandom_range(0, 1);
      a  = (r == 0) ? 28'(64 + $urandom_range(0, 200)) : 28'($urandom_range(0, 63));
      do_frame(r != 9, 0, ld[0], !ld[0], a,
               {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))}, $urandom,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1, -1);
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);

    // LATENCY=3 instance: reset during the second wait frame aborts the load
    do_frame(1, 1, 1, 0, 28'h10, 3'd2, $urandom, -1, -1);
    chk("busy3_wait", busy3, 1);
    do_frame(0, 1, 0, 0, 28'h0, 3'd2, $urandom, -1, -1);
    chk("busy3_wait2", busy3, 1);
    do_frame(0, 1, 0, 0, 28'h0, 3'd2, $urandom, -1, 3);
    for (int i = 0; i < 5; i++) do_frame(0, 1, 0, 0, 28'h0, 3'd2, $urandom, -1, -1);
    chk("ldr3_never", ldr3_seen, 0);
    chk("busy3_idle", busy3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p19_tinyqv_mem_responder.md
P19_TINYQV_MEM_RESPONDER -- requirements
Module: p19_tinyqv_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, giving the byte-address width of the backing store (2^ADDR_BITS bytes, 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 1, legal 1..3, giving the number of wait frames between the address frame and the data frame.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port counter  input  3  core sub-cycle counter; increments every clock; one frame = counts 0..7.
REQ-006 SHALL have port address_ready  input  1  core strobe at count 7; addr_in, is_load, is_store and mem_op are valid.
REQ-007 SHALL have port addr_in  input  28  byte address from the core.
REQ-008 SHALL have ports is_load and is_store  input  1 each  access type; exactly one is high with address_ready.
REQ-009 SHALL have port mem_op  input  3  [1:0]: 00 byte, 01 half, 10 word; [2] unsigned (ignored here).
REQ-010 SHALL have port data_in  input  4  core store-data nibble; nibble n valid at count n.
REQ-011 SHALL have port data_out  output  4  load-data nibble to the core; nibble n at count n of the data frame; 0 otherwise.
REQ-012 SHALL have port load_data_ready  output  1  high for every clock of the data frame.
REQ-013 SHALL have port busy  output  1  high while a load is in WAIT or DATA.
REQ-014 SHALL have port err  output  1  one-clock pulse at count 7 of a misaligned address frame.

Function
REQ-015 SHALL shift data_in into a 32-bit capture register every clock, nibble 0 at bits 3:0; at count 7 the word is {data_in, capture[31:4]}.
REQ-016 SHALL commit a store on address_ready&&is_store: byte lanes from mem_op[1:0] and addr_in[1:0]; store data taken from word[7:0], [15:0] or [31:0], shifted to the lane.
REQ-017 SHALL make a committed store visible to any load whose address frame starts on the next clock or later.
REQ-018 SHALL implement states IDLE, WAIT, DATA; IDLE->WAIT on address_ready&&is_load; WAIT->DATA after LATENCY complete frames; DATA->IDLE at count 7.
REQ-019 SHALL latch addr_in and the addressed 32-bit word when the address frame is accepted; data_out = word >> (8*addr_in[1:0]) over the data frame, zero-filled above.
REQ-020 SHALL assert load_data_ready exactly at counts 0..7 of the data frame, e.g. with LATENCY=1, address at count 7 of frame F gives data in frame F+2.
REQ-021 SHALL treat an access as misaligned when (half && addr[0]) or (word && addr[1:0]!=0); it pulses err, drops the store, and still serves the load with zeros.
REQ-022 SHALL treat addr_in[27:ADDR_BITS]!=0 as out of range: the store is dropped, the load returns zeros, and err stays low.
REQ-023 SHALL ignore address_ready while busy; the state, latched address and data frame are unaffected.
REQ-024 SHALL commit a store that arrives while busy; the in-flight load returns its already-latched word.
REQ-025 SHALL ignore address_ready when counter != 7.

Reset
REQ-026 SHALL, with rst high at a rising edge, enter IDLE and hold load_data_ready=0, data_out=0, busy=0, err=0 from the next clock.
REQ-027 SHALL abort an in-flight load on reset mid-operation; no data frame follows.
REQ-028 SHALL leave the backing-store contents undefined and uncleared by reset.
REQ-029 SHALL not commit a store whose address frame coincides with rst.

Structure
REQ-030 SHALL place the mem_op size encodings and the state enum in the shared tinyqv package.
REQ-031 SHALL contain one sub-module, p19_tinyqv_mem_array: a 2^(ADDR_BITS-2) x 32 array with 4 byte-write enables and an asynchronous word read.

Verification
REQ-032 SHALL test a word store then a word load: store 0xDEADBEEF to 0x10, load 0x10 with LATENCY=1 -> data frame 2 frames later with nibbles F,E,E,B,D,A,E,D.
REQ-033 SHALL test a byte store: after REQ-032, store byte 0x5A to 0x12, word load 0x10 -> 0xDE5ABEEF; byte load 0x13 -> 0x000000DE.
REQ-034 SHALL test a misaligned access: half load at 0x11 -> err pulse at count 7, data frame all zero; half store at 0x11 -> memory unchanged.
REQ-035 SHALL test out of range: store to 0x100 (ADDR_BITS=6) dropped and err low; load from 0x100 -> zeros.
REQ-036 SHALL test reset mid-WAIT with LATENCY=3: load issued, rst at frame 2 -> load_data_ready never asserts, busy=0 next clock.
REQ-037 SHALL test address_ready while busy: second load ignored, first load data returned, state IDLE after one data frame.
